axi4_sram_target: RTL and testbench

//  AXI4 slave (responder) backed by an internal word-addressed memory array; the active

---
 rtl/axi4_sram_target.sv | 159 +++++++++++++++
 tb/tb_axi4_sram_target.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_sram_target.sv
// AXI4 slave backed by a word-addressed memory array: INCR bursts, full-width beats,
// a single transaction in flight, round-robin between write and read address channels.
module axi4_sram_target #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 32,
    parameter int AXI4_ID_WIDTH      = 4,
    parameter int DEPTH              = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [AXI4_ID_WIDTH-1:0]        AWID,
    input  logic [AXI4_ADDRESS_WIDTH-1:0]   AWADDR,
    input  logic [7:0]                      AWLEN,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [AXI4_DATA_WIDTH-1:0]      WDATA,
    input  logic [AXI4_DATA_WIDTH/8-1:0]    WSTRB,
    input  logic                            WLAST,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [AXI4_ID_WIDTH-1:0]        BID,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [AXI4_ID_WIDTH-1:0]        ARID,
    input  logic [AXI4_ADDRESS_WIDTH-1:0]   ARADDR,
    input  logic [7:0]                      ARLEN,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [AXI4_ID_WIDTH-1:0]        RID,
    output logic [AXI4_DATA_WIDTH-1:0]      RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RLAST,
    output logic                            RVALID,
    input  logic                            RREADY
);
    localparam int BYTES  = AXI4_DATA_WIDTH / 8;
    localparam int OFF    = $clog2(BYTES);
    localparam int IDX_W  = $clog2(DEPTH);
    // one spare bit so incrementing past the top of the address space never wraps back in range
    localparam int FIDX_W = AXI4_ADDRESS_WIDTH - OFF + 1;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

    state_t                     state;
    logic                       last_wr;
    logic [FIDX_W-1:0]          idx;
    logic [7:0]                 count;
    logic                       err;
    logic [AXI4_ID_WIDTH-1:0]   bid_q;
    logic [AXI4_ID_WIDTH-1:0]   rid_q;
    logic [AXI4_DATA_WIDTH-1:0] mem [DEPTH];

    logic             idle;
    logic             grant_w;
    logic             grant_r;
    logic             in_range;
    logic [IDX_W-1:0] widx;
    logic             cnt_zero;

    assign idle     = (state == IDLE);
    assign grant_w  = AWVALID && (!ARVALID || !last_wr);
    assign grant_r  = ARVALID && (!AWVALID || last_wr);
    assign in_range = (idx[FIDX_W-1:IDX_W] == '0);
    assign widx     = idx[IDX_W-1:0];
    assign cnt_zero = (count == 8'd0);

    assign AWREADY = idle && grant_w;
    assign ARREADY = idle && grant_r;
    assign WREADY  = (state == WR_DATA);
    assign BVALID  = (state == WR_RESP);
    assign BID     = bid_q;
    assign BRESP   = (BVALID && err) ? SLVERR : OKAY;
    assign RVALID  = (state == RD_DATA);
    assign RID     = rid_q;
    assign RDATA   = (RVALID && in_range) ? mem[widx] : '0;
    assign RRESP   = (RVALID && !in_range) ? SLVERR : OKAY;
    assign RLAST   = RVALID && cnt_zero;

    generate
        if (OFF > 0) begin : g_unused
            logic unused_addr_bits;
            assign unused_addr_bits = ^{AWADDR[OFF-1:0], ARADDR[OFF-1:0]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last_wr <= 1'b0;
            idx     <= '0;
            count   <= '0;
            err     <= 1'b0;
            bid_q   <= '0;
            rid_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (AWVALID && AWREADY) begin
                        bid_q <= AWID;
                        idx   <= {1'b0, AWADDR[AXI4_ADDRESS_WIDTH-1:OFF]};
                        count <= AWLEN;
                        err   <= 1'b0;
                        state <= WR_DATA;
                    end else if (ARVALID && ARREADY) begin
                        rid_q <= ARID;
                        idx   <= {1'b0, ARADDR[AXI4_ADDRESS_WIDTH-1:OFF]};
                        count <= ARLEN;
                        state <= RD_DATA;
                    end
                end
                WR_DATA: begin
                    if (WVALID) begin
                        // the beat counter ends the burst; a misplaced WLAST only flags an error
                        if (!in_range || (WLAST != cnt_zero))
                            err <= 1'b1;
                        if (cnt_zero) begin
                            state <= WR_RESP;
                        end else begin
                            count <= count - 8'd1;
                            idx   <= idx + FIDX_W'(1);
                        end
                    end
                end
                WR_RESP: begin
                    if (BREADY) begin
                        state   <= IDLE;
                        last_wr <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (RREADY) begin
                        if (cnt_zero) begin
                            state   <= IDLE;
                            last_wr <= 1'b0;
                        end else begin
                            count <= count - 8'd1;
                            idx   <= idx + FIDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (state == WR_DATA && WVALID && in_range) begin
            for (int b = 0; b < BYTES; b++) begin
                if (WSTRB[b])
                    mem[widx][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi4_sram_target.sv
// Directed bench for axi4_sram_target: a reference memory model feeds expected B/R
// responses into queues that are popped as the DUT produces them.
module tb_axi4_sram_target;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  AWID, ARID, BID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [7:0]  AWLEN, ARLEN;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    axi4_sram_target #(
        .AXI4_ADDRESS_WIDTH(32), .AXI4_DATA_WIDTH(32), .AXI4_ID_WIDTH(4), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;
    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] wbuf  [256];
    logic [3:0]  sbuf  [256];
    rexp_t       r_q[$];
    bexp_t       b_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        @(negedge clk);
        AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
        #1;
        while (!AWREADY && n < 100) begin @(negedge clk); #1; n++; end
        chk("aw_accept", 64'(AWREADY), 64'(1));
        @(posedge clk); #1 AWVALID = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        @(negedge clk);
        ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
        #1;
        while (!ARREADY && n < 100) begin @(negedge clk); #1; n++; end
        chk("ar_accept", 64'(ARREADY), 64'(1));
        @(posedge clk); #1 ARVALID = 1'b0;
    endtask

    task automatic send_w(input int len, input int lastpos);
        for (int b = 0; b <= len; b++) begin
            int n = 0;
            @(negedge clk);
            WDATA = wbuf[b]; WSTRB = sbuf[b]; WLAST = (b == lastpos); WVALID = 1'b1;
            #1;
            while (!WREADY && n < 100) begin @(negedge clk); #1; n++; end
            chk("w_accept", 64'(WREADY), 64'(1));
            @(posedge clk); #1 WVALID = 1'b0; WLAST = 1'b0;
        end
    endtask

    task automatic get_b();
        int    n = 0;
        bexp_t e;
        @(negedge clk);
        BREADY = 1'b1;
        #1;
        while (!BVALID && n < 100) begin @(negedge clk); #1; n++; end
        chk("b_valid", 64'(BVALID), 64'(1));
        chk("b_q_nonempty", 64'(b_q.size() > 0), 64'(1));
        if (b_q.size() > 0) begin
            e = b_q.pop_front();
            chk("bid", 64'(BID), 64'(e.id));
            chk("bresp", 64'(BRESP), 64'(e.resp));
        end
        @(posedge clk); #1 BREADY = 1'b0;
    endtask

    // collects n beats; with toggle set, RREADY alternates and stalled data must hold
    task automatic recv_r(input int n, input logic toggle);
        int          got = 0;
        int          cyc = 0;
        logic [31:0] held = '0;
        logic        held_v = 1'b0;
        rexp_t       e;
        while (got < n && cyc < 2000) begin
            @(negedge clk);
            RREADY = toggle ? cyc[0] : 1'b1;
            #1;
            if (held_v) begin
                chk("r_hold", 64'(RDATA), 64'(held));
                held_v = 1'b0;
            end
            if (RVALID && RREADY) begin
                e = r_q.pop_front();
                chk("rdata", 64'(RDATA), 64'(e.data));
                chk("rresp", 64'(RRESP), 64'(e.resp));
                chk("rlast", 64'(RLAST), 64'(e.last));
                chk("rid", 64'(RID), 64'(e.id));
                got++;
            end else if (RVALID) begin
                held   = RDATA;
                held_v = 1'b1;
            end
            cyc++;
        end
        chk("r_beats", 64'(got), 64'(n));
        @(posedge clk); #1 RREADY = 1'b0;
    endtask

    task automatic model_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                               input int lastpos);
        logic        err = (lastpos != len);
        logic [31:0] ix;
        for (int b = 0; b <= len; b++) begin
            ix = (addr >> 2) + 32'(b);
            if (ix < DEPTH) begin
                for (int i = 0; i < 4; i++)
                    if (sbuf[b][i]) model[ix[7:0]][i*8 +: 8] = wbuf[b][i*8 +: 8];
            end else begin
                err = 1'b1;
            end
        end
        b_q.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
    endtask

    task automatic model_read(input logic [3:0] id, input logic [31:0] addr, input int len);
        logic [31:0] ix;
        for (int b = 0; b <= len; b++) begin
            ix = (addr >> 2) + 32'(b);
            r_q.push_back('{id: id, data: (ix < DEPTH) ? model[ix[7:0]] : 32'h0,
                            resp: (ix < DEPTH) ? 2'b00 : 2'b10, last: (b == len)});
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int lastpos);
        model_write(id, addr, len, lastpos);
        send_aw(id, addr, 8'(len));
        send_w(len, lastpos);
        get_b();
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic toggle);
        model_read(id, addr, len);
        send_ar(id, addr, 8'(len));
        recv_r(len + 1, toggle);
    endtask

    task automatic fill(input logic [31:0] base, input int len, input logic [3:0] strb);
        for (int b = 0; b <= len; b++) begin
            wbuf[b] = base + 32'(b);
            sbuf[b] = strb;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 'x;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'({AWREADY, WREADY, ARREADY}), 64'(0));
        chk("rst_valid", 64'({BVALID, RVALID, RLAST}), 64'(0));
        chk("rst_ids", 64'({BID, RID, BRESP, RRESP}), 64'(0));
        rst = 1'b0;

        // simultaneous AW/AR from reset: write wins; right after a write, read wins
        fill(32'h33333333, 0, 4'hF);
        model_write(4'h3, 32'h20, 0, 0);
        @(negedge clk);
        AWID = 4'h3; AWADDR = 32'h20; AWLEN = 8'd0; AWVALID = 1'b1;
        ARID = 4'h5; ARADDR = 32'h20; ARLEN = 8'd0; ARVALID = 1'b1;
        #1;
        chk("rr_first_aw", 64'({AWREADY, ARREADY}), 64'(2'b10));
        @(posedge clk); #1 AWVALID = 1'b0;
        send_w(0, 0);
        get_b();
        AWID = 4'h6; AWADDR = 32'h24; AWLEN = 8'd0; AWVALID = 1'b1;
        #1;
        chk("rr_second_ar", 64'({AWREADY, ARREADY}), 64'(2'b01));
        model_read(4'h5, 32'h20, 0);
        send_ar(4'h5, 32'h20, 8'd0);
        recv_r(1, 1'b0);
        fill(32'h44444444, 0, 4'hF);
        model_write(4'h6, 32'h24, 0, 0);
        send_aw(4'h6, 32'h24, 8'd0);
        send_w(0, 0);
        get_b();
        do_read(4'h6, 32'h24, 0, 1'b0);

        // single write then read back
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        do_write(4'h1, 32'h10, 0, 0);
        do_read(4'h2, 32'h10, 0, 1'b0);

        // 4-beat burst with a partial strobe on beat 2
        wbuf[0] = 32'hAAAA5555; sbuf[0] = 4'hF;
        do_write(4'h7, 32'h104, 0, 0);
        fill(32'h1, 3, 4'hF);
        sbuf[1] = 4'h3;
        do_write(4'h8, 32'h100, 3, 3);
        do_read(4'h8, 32'h100, 3, 1'b0);

        // out-of-range write is dropped and must not alias onto word 0
        wbuf[0] = 32'h12345678; sbuf[0] = 4'hF;
        do_write(4'hA, 32'h0, 0, 0);
        wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
        do_write(4'hB, DEPTH * 4, 0, 0);
        do_read(4'hB, 32'h0, 0, 1'b0);
        do_read(4'hC, DEPTH * 4, 1, 1'b0);

        // early WLAST: all 4 beats still taken, SLVERR; then a stalled read
        fill(32'h50, 3, 4'hF);
        do_write(4'hD, 32'h200, 3, 1);
        do_read(4'hD, 32'h200, 3, 1'b1);

        // reset in the middle of an 8-beat read
        fill(32'h700, 7, 4'hF);
        do_write(4'h4, 32'h300, 7, 7);
        model_read(4'hE, 32'h300, 7);
        send_ar(4'hE, 32'h300, 8'd7);
        recv_r(3, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_rvalid", 64'(RVALID), 64'(0));
        r_q.delete();
        @(negedge clk);
        rst = 1'b0;
        do_read(4'h9, 32'h300, 7, 1'b0);
        fill(32'h900, 1, 4'hF);
        do_write(4'hF, 32'h380, 1, 1);
        do_read(4'h2, 32'h37C, 2, 1'b1);

        chk("queues_drained", 64'(r_q.size() + b_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
